// File: rtl/guess_evaluator.sv
// Number-guessing game evaluator: latches a 1..3 digit BCD secret, scores guesses
// with higher/lower hints and a guess budget. Define LFSR_SECRET_EN for an internal random secret.
module guess_evaluator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] max_digits,
  input  logic [2:0] max_guesses,
  input  logic       confirm,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  input  logic [3:0] secret_digit_1,
  input  logic [3:0] secret_digit_2,
  input  logic [3:0] secret_digit_3,
  output logic [2:0] guesses_left,
  output logic       hint_higher,
  output logic       hint_lower,
  output logic       result_valid,
  output logic       bad_guess,
  output logic       win,
  output logic       lose,
  output logic       playing
);

  typedef enum logic [2:0] {IDLE, PLAY, CHECK, WIN, LOSE} state_t;

  state_t      state, state_n;
  logic        confirm_q;
  logic [1:0]  md_q;
  logic [11:0] guess_q, secret_q;
  logic [11:0] secret_src, guess_m;
  logic [1:0]  md_c;
  logic [2:0]  mg_c, gl_dec;
  logic        conf_edge, bad_digit, eq, lt;

  // Digits above the active count are forced to zero.
  function automatic logic [11:0] mask_digits(input logic [11:0] v, input logic [1:0] md);
    logic [11:0] r;
    r = v;
    if (md < 2'd3) r[11:8] = 4'd0;
    if (md < 2'd2) r[7:4]  = 4'd0;
    return r;
  endfunction

  assign md_c      = (max_digits == 2'd0) ? 2'd1 : max_digits;
  assign mg_c      = (max_guesses == 3'd0) ? 3'd1 : max_guesses;
  assign conf_edge = confirm & ~confirm_q;
  assign guess_m   = mask_digits({guess_digit_3, guess_digit_2, guess_digit_1}, md_q);
  assign bad_digit = (guess_m[3:0] > 4'd9) | (guess_m[7:4] > 4'd9) | (guess_m[11:8] > 4'd9);
  // Valid BCD orders the same as its packed binary value.
  assign eq        = (guess_q == secret_q);
  assign lt        = (guess_q < secret_q);
  assign gl_dec    = (guesses_left != 3'd0) ? guesses_left - 3'd1 : 3'd0;

`ifdef LFSR_SECRET_EN
  logic [11:0] lfsr;

  function automatic logic [3:0] fold(input logic [3:0] v);
    return (v > 4'd9) ? v - 4'd6 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 12'h001;
    else        lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
  end

  assign secret_src = {fold(lfsr[11:8]), fold(lfsr[7:4]), fold(lfsr[3:0])};
`else
  assign secret_src = {secret_digit_3, secret_digit_2, secret_digit_1};
`endif

  always_comb begin
    state_n = state;
    case (state)
      PLAY:  if (conf_edge && !bad_digit) state_n = CHECK;
      CHECK: begin
        if (eq)                  state_n = WIN;
        else if (gl_dec == 3'd0) state_n = LOSE;
        else                     state_n = PLAY;
      end
      default: state_n = state;
    endcase
    if (start) state_n = PLAY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      confirm_q    <= 1'b0;
      md_q         <= 2'd0;
      guess_q      <= 12'd0;
      secret_q     <= 12'd0;
      guesses_left <= 3'd0;
      hint_higher  <= 1'b0;
      hint_lower   <= 1'b0;
      result_valid <= 1'b0;
      bad_guess    <= 1'b0;
    end else begin
      confirm_q    <= confirm;
      result_valid <= 1'b0;
      bad_guess    <= 1'b0;
      if (start) begin
        md_q         <= md_c;
        secret_q     <= mask_digits(secret_src, md_c);
        guesses_left <= mg_c;
        hint_higher  <= 1'b0;
        hint_lower   <= 1'b0;
      end else begin
        case (state)
          PLAY: if (conf_edge) begin
            if (bad_digit) bad_guess <= 1'b1;
            else           guess_q   <= guess_m;
          end
          CHECK: begin
            result_valid <= 1'b1;
            if (eq) begin
              hint_higher <= 1'b0;
              hint_lower  <= 1'b0;
            end else begin
              guesses_left <= gl_dec;
              hint_higher  <= lt;
              hint_lower   <= ~lt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign win     = (state == WIN);
  assign lose    = (state == LOSE);
  assign playing = (state == PLAY) || (state == CHECK);

endmodule

// File: tb/tb_guess_evaluator.sv
// Scoreboard bench for guess_evaluator: stimulus pushes expected pulses, a monitor pops and checks.
module tb_guess_evaluator;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, confirm = 1'b0;
  logic [1:0] max_digits = 2'd3;
  logic [2:0] max_guesses = 3'd3;
  logic [3:0] g1 = 0, g2 = 0, g3 = 0, s1 = 0, s2 = 0, s3 = 0;
  logic [2:0] guesses_left;
  logic       hint_higher, hint_lower, result_valid, bad_guess, win, lose, playing;

  guess_evaluator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_digits(max_digits),
    .max_guesses(max_guesses), .confirm(confirm),
    .guess_digit_1(g1), .guess_digit_2(g2), .guess_digit_3(g3),
    .secret_digit_1(s1), .secret_digit_2(s2), .secret_digit_3(s3),
    .guesses_left(guesses_left), .hint_higher(hint_higher), .hint_lower(hint_lower),
    .result_valid(result_valid), .bad_guess(bad_guess), .win(win), .lose(lose),
    .playing(playing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         bad;
    int         cyc;
    bit         win, lose, play, hh, hl;
    logic [2:0] gl;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid || bad_guess) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got rv=%0b bad=%0b expected none (cycle %0d)",
                 result_valid, bad_guess, cyc);
      end else begin
        e = sb.pop_front();
        chk("bad_guess", bad_guess, e.bad);
        chk("result_valid", result_valid, !e.bad);
        chk("latency", cyc, e.cyc);
        chk("win", win, e.win);
        chk("lose", lose, e.lose);
        chk("playing", playing, e.play);
        chk("guesses_left", guesses_left, e.gl);
        chk("hint_higher", hint_higher, e.hh);
        chk("hint_lower", hint_lower, e.hl);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; confirm = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic begin_game(input logic [1:0] md, input logic [2:0] mg,
                            input logic [3:0] d3, d2, d1);
    max_digits = md; max_guesses = mg; s3 = d3; s2 = d2; s1 = d1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  // Submit a guess and queue the pulse it should produce.
  task automatic guess(input logic [3:0] d3, d2, d1, input bit bad, w, l, p, hh, hl,
                       input logic [2:0] gl);
    g3 = d3; g2 = d2; g1 = d1; confirm = 1'b1;
    sb.push_back('{bad, cyc + (bad ? 1 : 2), w, l, p, hh, hl, gl});
    tick(1);
    confirm = 1'b0;
    tick(4);
  endtask

  // Confirm edge that must produce no pulse.
  task automatic poke(input logic [3:0] d3, d2, d1);
    g3 = d3; g2 = d2; g1 = d1; confirm = 1'b1;
    tick(1);
    confirm = 1'b0;
    tick(4);
  endtask

`ifdef LFSR_SECRET_EN
  logic [11:0] m_lfsr;
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 12'h001;
    else        m_lfsr <= {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[5] ^ m_lfsr[3] ^ m_lfsr[0]};
  end

  function automatic logic [3:0] fold(input logic [3:0] v);
    return (v > 4'd9) ? v - 4'd6 : v;
  endfunction

  task automatic lfsr_run(output logic [11:0] sec);
    logic [11:0] v;
    @(negedge clk);
    do_reset();
    tick(19);
    v = m_lfsr;
    sec = {fold(v[11:8]), fold(v[7:4]), fold(v[3:0])};
    begin_game(2'd3, 3'd3, 4'd0, 4'd0, 4'd0);
  endtask
`endif

  initial begin
`ifdef LFSR_SECRET_EN
    logic [11:0] sec_a, sec_b;
    lfsr_run(sec_a);
    for (int k = 0; k < 3; k++) chk("lfsr_digit_range", (sec_a[k*4 +: 4] <= 4'd9), 1);
    guess(sec_a[11:8], sec_a[7:4], sec_a[3:0], 0, 1, 0, 0, 0, 0, 3'd3);
    lfsr_run(sec_b);
    chk("lfsr_repeatable", sec_b, sec_a);
    guess(sec_a[11:8], sec_a[7:4], sec_a[3:0], 0, 1, 0, 0, 0, 0, 3'd3);
`else
    @(negedge clk);
    do_reset();
    chk("rst_guesses_left", guesses_left, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_playing", playing, 0);
    chk("rst_hints", {hint_higher, hint_lower}, 0);
    chk("rst_pulses", {result_valid, bad_guess}, 0);

    // Exact match, then confirm in WIN must be ignored
    begin_game(2'd3, 3'd3, 4'd4, 4'd7, 4'd2);
    chk("start_playing", playing, 1);
    guess(4'd4, 4'd7, 4'd2, 0, 1, 0, 0, 0, 0, 3'd3);
    poke(4'd1, 4'd1, 4'd1);
    chk("win_holds", win, 1);

    // Three misses exhaust the budget; mid-game max_guesses change is ignored
    begin_game(2'd3, 3'd3, 4'd4, 4'd7, 4'd2);
    guess(4'd1, 4'd0, 4'd0, 0, 0, 0, 1, 1, 0, 3'd2);
    max_guesses = 3'd7;
    guess(4'd9, 4'd0, 4'd0, 0, 0, 0, 1, 0, 1, 3'd1);
    guess(4'd5, 4'd0, 4'd0, 0, 0, 1, 0, 0, 1, 3'd0);
    poke(4'd4, 4'd7, 4'd2);
    chk("lose_holds", lose, 1);

    // One active digit: upper digits of secret and guess are masked
    begin_game(2'd1, 3'd3, 4'd3, 4'd8, 4'd5);
    guess(4'd9, 4'd9, 4'd5, 0, 1, 0, 0, 0, 0, 3'd3);

    // Non-BCD digit is rejected without spending a guess
    begin_game(2'd3, 3'd2, 4'd4, 4'd7, 4'd2);
    guess(4'd4, 4'hB, 4'd2, 1, 0, 0, 1, 0, 0, 3'd2);
    guess(4'd4, 4'd7, 4'd1, 0, 0, 0, 1, 1, 0, 3'd1);

    // Zero max_digits / max_guesses clamp to 1
    begin_game(2'd0, 3'd0, 4'd0, 4'd0, 4'd7);
    chk("clamp_guesses", guesses_left, 1);
    guess(4'd0, 4'd0, 4'd3, 0, 0, 1, 0, 1, 0, 3'd0);

    // Held confirm counts once
    begin_game(2'd3, 3'd4, 4'd4, 4'd7, 4'd2);
    g3 = 4'd1; g2 = 4'd2; g1 = 4'd3; confirm = 1'b1;
    sb.push_back('{0, cyc + 2, 0, 0, 1, 1, 0, 3'd3});
    tick(10);
    confirm = 1'b0;
    tick(3);

    // start wins over a simultaneous confirm edge
    max_guesses = 3'd5; g3 = 4'd4; g2 = 4'd7; g1 = 4'd2;
    start = 1'b1; confirm = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    confirm = 1'b0;
    tick(3);
    chk("start_prio_gl", guesses_left, 5);
    chk("start_prio_play", playing, 1);
    chk("start_prio_win", win, 0);

    // Reset during CHECK aborts without a pulse
    confirm = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; confirm = 1'b0;
    tick(3);
    chk("abort_gl", guesses_left, 0);
    chk("abort_state", {win, lose, playing}, 0);
`endif
    tick(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/guess_evaluator.md
GUESS_EVALUATOR -- requirements
Module: guess_evaluator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  level; high starts a new game
- max_digits  in  2  active digit count 1..3; 0 treated as 1
- max_guesses  in  3  guess budget 1..7; 0 treated as 1
- confirm  in  1  guess submit; rising-edge detected
- guess_digit_1/2/3  in  4 each  BCD guess; digit_1 is least significant
- secret_digit_1/2/3  in  4 each  BCD secret (used only when LFSR_SECRET_EN is undefined)
- guesses_left  out  3  remaining guesses
- hint_higher  out  1  last wrong guess was below the secret
- hint_lower  out  1  last wrong guess was above the secret
- result_valid  out  1  one-cycle pulse when a guess has been evaluated
- bad_guess  out  1  one-cycle pulse when a guess is rejected
- win  out  1  level, high in state WIN
- lose  out  1  level, high in state LOSE
- playing  out  1  level, high in states PLAY and CHECK

Function
REQ-003 The FSM SHALL have the states IDLE, PLAY, CHECK, WIN and LOSE, and SHALL leave IDLE only on start.
REQ-004 When start is high in any state, the block SHALL on the next edge:
- latch the clamped max_digits and max_guesses;
- latch the secret;
- set guesses_left to the clamped max_guesses;
- clear both hints;
- enter PLAY.
REQ-005 start SHALL take priority over a simultaneous confirm edge.
REQ-006 A confirm edge is the sampled condition confirm=1 with the previous-cycle confirm=0; a held confirm SHALL count once.
REQ-007 A confirm edge in IDLE, CHECK, WIN or LOSE SHALL be ignored.
REQ-008 On a confirm edge in PLAY, the block SHALL register the guess with digits above max_digits forced to 0, then enter CHECK.
REQ-009 If any active guess digit is greater than 9, the block SHALL pulse bad_guess, leave guesses_left and the hints unchanged, and stay in PLAY.
REQ-010 In CHECK, the block SHALL compare guess and secret as decimal magnitude (digit_3 first, then digit_2, then digit_1), using only active digits.
REQ-011 On the CHECK exit edge, result_valid SHALL pulse high for exactly one cycle.
REQ-012 If the guess equals the secret, the block SHALL enter WIN, clear both hints, and leave guesses_left unchanged.
REQ-013 If the guess does not equal the secret, the block SHALL:
- decrement guesses_left;
- set exactly one of hint_higher or hint_lower;
- enter LOSE if guesses_left becomes 0, otherwise return to PLAY.
REQ-014 Latency SHALL be as follows: confirm edge sampled at edge N, CHECK entered at N, result outputs updated at edge N+1.
REQ-015 guesses_left SHALL never wrap below 0.
REQ-016 WIN and LOSE SHALL hold until start or reset.
REQ-017 Changes on the max_digits and max_guesses inputs during a game SHALL have no effect until the next start.

Reset
REQ-018 While rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- set guesses_left=0;
- drive all 1-bit outputs to 0;
- clear the confirm edge history;
- clear the registered guess and secret;
- seed the LFSR to 12'h001.
REQ-019 A reset asserted during CHECK SHALL abort the evaluation, with no result_valid pulse.

Configuration
REQ-020 With LFSR_SECRET_EN defined, the block SHALL use a 12-bit Fibonacci LFSR as follows:
- polynomial x^12+x^6+x^4+x+1;
- steps every cycle outside reset;
- on start, nibble k supplies secret digit k, with any nibble value above 9 replaced by value-6;
- inactive digits forced to 0;
- the secret_digit_* ports are ignored.
REQ-021 Without LFSR_SECRET_EN, the block SHALL latch the secret from the secret_digit_* ports on start (inactive digits forced to 0) and SHALL contain no LFSR logic.

Verification
REQ-022 The bench SHALL cover the following scenarios (all without LFSR_SECRET_EN unless stated):
- Reset, then start with secret=4-7-2 (d3-d2-d1), max_digits=3, max_guesses=3, then confirm guess 472 -> result_valid pulse 2 edges after the confirm edge, win=1, guesses_left=3.
- Same setup, guesses 100, then 900, then 500 -> hint_higher=1 then hint_lower=1, guesses_left 2, then 1, then 0, lose=1 after the third guess.
- max_digits=1, secret digit_1=5, guess digits=9-9-5 -> upper digits masked, win=1.
- Guess digit_2=4'hB -> bad_guess pulse, guesses_left unchanged, still playing.
- confirm held high 10 cycles -> exactly one result_valid pulse; start asserted on the same edge as a confirm edge -> no evaluation, guesses_left reloaded.
- With LFSR_SECRET_EN defined, reset then start at cycle 20 -> every secret digit 0..9; identical secrets across two runs with identical timing.
